// File: rtl/handshake_monitor.sv
// Passive monitor for N_CH ready/valid channels: counts transfers, flags drop/data/stall violations.
// Per-channel FSM: IDLE = nothing outstanding, PEND = valid seen without ready. Assertions with HANDSHAKE_MONITOR_ASSERT_EN.
module handshake_monitor #(
   parameter int N_CH      = 3,
   parameter int DATA_W    = 5,
   parameter int CNT_W     = 16,
   parameter int STALL_MAX = 15
) (
   input  logic                     CLK,
   input  logic                     ASYNCRESET,
   input  logic [N_CH-1:0]          valid,
   input  logic [N_CH-1:0]          ready,
   input  logic [N_CH*DATA_W-1:0]   data,
   input  logic                     clear,
   output logic [N_CH*CNT_W-1:0]    xfer_count,
   output logic [N_CH-1:0]          err_drop,
   output logic [N_CH-1:0]          err_data,
   output logic [N_CH-1:0]          err_stall,
   output logic                     any_err
);

   localparam int                 STALL_W   = $clog2(STALL_MAX + 1);
   localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(STALL_MAX);
   localparam logic [CNT_W-1:0]   CNT_SAT   = '1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PEND = 1'b1
   } state_t;

   for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      state_t              r_state;
      state_t              w_state_nxt;
      logic [DATA_W-1:0]   r_hold;
      logic [DATA_W-1:0]   w_hold_nxt;
      logic [DATA_W-1:0]   w_data;
      logic [STALL_W-1:0]  r_stall;
      logic [STALL_W-1:0]  w_stall_nxt;
      logic [CNT_W-1:0]    r_cnt;
      logic [CNT_W-1:0]    w_cnt_nxt;
      logic                r_drop;
      logic                r_derr;
      logic                r_serr;
      logic                w_xfer;
      logic                w_drop_ev;
      logic                w_data_ev;
      logic                w_stall_ev;

      assign w_data = data[gi*DATA_W +: DATA_W];

      always_comb begin
         w_state_nxt = r_state;
         w_hold_nxt  = r_hold;
         w_stall_nxt = r_stall;
         w_xfer      = 1'b0;
         w_drop_ev   = 1'b0;
         w_data_ev   = 1'b0;
         w_stall_ev  = 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (valid[gi] && ready[gi]) begin
                  w_xfer = 1'b1;
               end else if (valid[gi]) begin
                  w_state_nxt = ST_PEND;
                  w_hold_nxt  = w_data;
                  w_stall_nxt = STALL_W'(1);
                  w_stall_ev  = (STALL_MAX == 1);
               end
            end
            ST_PEND: begin
               if (!valid[gi]) begin
                  w_drop_ev   = 1'b1;
                  w_state_nxt = ST_IDLE;
                  w_stall_nxt = '0;
               end else begin
                  // Hold keeps the first captured payload; later mismatches only set the flag.
                  w_data_ev = (w_data != r_hold);
                  if (ready[gi]) begin
                     w_xfer      = 1'b1;
                     w_state_nxt = ST_IDLE;
                     w_stall_nxt = '0;
                  end else if (r_stall != STALL_LIM) begin
                     w_stall_nxt = r_stall + STALL_W'(1);
                     w_stall_ev  = (r_stall == STALL_LIM - STALL_W'(1));
                  end
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_stall_nxt = '0;
            end
         endcase

         w_cnt_nxt = (w_xfer && (r_cnt != CNT_SAT)) ? r_cnt + CNT_W'(1) : r_cnt;

         if (clear) begin
            w_state_nxt = ST_IDLE;
            w_hold_nxt  = '0;
            w_stall_nxt = '0;
            w_cnt_nxt   = '0;
         end
      end

      always_ff @(posedge CLK or posedge ASYNCRESET) begin
         if (ASYNCRESET) begin
            r_state <= ST_IDLE;
            r_hold  <= '0;
            r_stall <= '0;
            r_cnt   <= '0;
            r_drop  <= 1'b0;
            r_derr  <= 1'b0;
            r_serr  <= 1'b0;
         end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
            r_stall <= w_stall_nxt;
            r_cnt   <= w_cnt_nxt;
            r_drop  <= !clear && (r_drop || w_drop_ev);
            r_derr  <= !clear && (r_derr || w_data_ev);
            r_serr  <= !clear && (r_serr || w_stall_ev);
         end
      end

      assign xfer_count[gi*CNT_W +: CNT_W] = r_cnt;
      assign err_drop[gi]  = r_drop;
      assign err_data[gi]  = r_derr;
      assign err_stall[gi] = r_serr;

`ifdef HANDSHAKE_MONITOR_ASSERT_EN
      a_drop: assert property (@(posedge CLK) disable iff (ASYNCRESET) !w_drop_ev)
         else $error("handshake_monitor: channel %0d violated rule drop", gi);
      a_data: assert property (@(posedge CLK) disable iff (ASYNCRESET) !w_data_ev)
         else $error("handshake_monitor: channel %0d violated rule data", gi);
      a_stall: assert property (@(posedge CLK) disable iff (ASYNCRESET) !w_stall_ev)
         else $error("handshake_monitor: channel %0d violated rule stall", gi);
`else
`endif
   end

   assign any_err = |{err_drop, err_data, err_stall};

endmodule

// File: tb/tb_handshake_monitor.sv
// Bench for handshake_monitor: directed vector table, hand sequences, and randomized run against a transaction model.
module tb_handshake_monitor;
   localparam int N_CH = 3, DATA_W = 5, CNT_W = 4, STALL_MAX = 4;
   localparam int CMAX = (1 << CNT_W) - 1;

   logic                    CLK = 1'b0;
   logic                    ASYNCRESET = 1'b1;
   logic [N_CH-1:0]         valid = '0;
   logic [N_CH-1:0]         ready = '0;
   logic [N_CH*DATA_W-1:0]  data = '0;
   logic                    clear = 1'b0;
   logic [N_CH*CNT_W-1:0]   xfer_count;
   logic [N_CH-1:0]         err_drop, err_data, err_stall;
   logic                    any_err;

   handshake_monitor #(.N_CH(N_CH), .DATA_W(DATA_W), .CNT_W(CNT_W), .STALL_MAX(STALL_MAX)) dut (
      .CLK(CLK), .ASYNCRESET(ASYNCRESET), .valid(valid), .ready(ready), .data(data),
      .clear(clear), .xfer_count(xfer_count), .err_drop(err_drop), .err_data(err_data),
      .err_stall(err_stall), .any_err(any_err)
   );

   always #5 CLK = ~CLK;

   typedef logic [21:0] obs_t;
   typedef struct {
      logic [2:0]  v;
      logic [2:0]  r;
      logic [14:0] d;
      logic        clr;
      logic [11:0] cnt;
      logic [2:0]  drop;
      logic [2:0]  derr;
      logic [2:0]  serr;
      logic        ae;
   } vec_t;

   int total = 0;
   int bad = 0;

   // transaction-level reference: outstanding offer per channel plus sticky violation sets
   int         m_cnt[N_CH];
   bit         m_open[N_CH];
   logic [4:0] m_offer[N_CH];
   int         m_age[N_CH];
   bit         m_drop[N_CH], m_derr[N_CH], m_serr[N_CH];

   function automatic obs_t observe();
      return {xfer_count, err_drop, err_data, err_stall, any_err};
   endfunction

   task automatic check(input string name, input obs_t act, input obs_t exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic model_clear();
      for (int c = 0; c < N_CH; c++) begin
         m_cnt[c] = 0; m_open[c] = 0; m_offer[c] = '0; m_age[c] = 0;
         m_drop[c] = 0; m_derr[c] = 0; m_serr[c] = 0;
      end
   endtask

   task automatic model_edge();
      if (clear) begin
         model_clear();
         return;
      end
      for (int c = 0; c < N_CH; c++) begin
         logic [4:0] d;
         d = data[c*DATA_W +: DATA_W];
         if (m_open[c]) begin
            if (!valid[c]) begin
               m_drop[c] = 1; m_open[c] = 0; m_age[c] = 0;
            end else begin
               if (d != m_offer[c]) m_derr[c] = 1;
               if (ready[c]) begin
                  if (m_cnt[c] < CMAX) m_cnt[c]++;
                  m_open[c] = 0; m_age[c] = 0;
               end else begin
                  if (m_age[c] < STALL_MAX) m_age[c]++;
                  if (m_age[c] >= STALL_MAX) m_serr[c] = 1;
               end
            end
         end else if (valid[c]) begin
            if (ready[c]) begin
               if (m_cnt[c] < CMAX) m_cnt[c]++;
            end else begin
               m_open[c] = 1; m_offer[c] = d; m_age[c] = 1;
               if (m_age[c] >= STALL_MAX) m_serr[c] = 1;
            end
         end
      end
   endtask

   function automatic obs_t model_obs();
      obs_t o;
      logic [11:0] cnt;
      logic [2:0] dr, de, se;
      for (int c = 0; c < N_CH; c++) begin
         cnt[c*CNT_W +: CNT_W] = 4'(m_cnt[c]);
         dr[c] = m_drop[c]; de[c] = m_derr[c]; se[c] = m_serr[c];
      end
      o = {cnt, dr, de, se, |{dr, de, se}};
      return o;
   endfunction

   vec_t vecs[8];

   initial begin
      logic [2:0] rv;
      #1;
      check("reset_state", observe(), '0);
      @(posedge CLK); #1;
      check("reset_held", observe(), '0);
      ASYNCRESET = 1'b0;

      vecs[0] = '{3'b010, 3'b000, 15'h0000, 1'b0, 12'h000, 3'b000, 3'b000, 3'b000, 1'b0};
      vecs[1] = '{3'b010, 3'b000, 15'h0000, 1'b0, 12'h000, 3'b000, 3'b000, 3'b000, 1'b0};
      vecs[2] = '{3'b000, 3'b000, 15'h0000, 1'b0, 12'h000, 3'b010, 3'b000, 3'b000, 1'b1};
      vecs[3] = '{3'b100, 3'b000, 15'h2800, 1'b0, 12'h000, 3'b010, 3'b000, 3'b000, 1'b1};
      vecs[4] = '{3'b100, 3'b000, 15'h2C00, 1'b0, 12'h000, 3'b010, 3'b100, 3'b000, 1'b1};
      vecs[5] = '{3'b100, 3'b100, 15'h2C00, 1'b0, 12'h100, 3'b010, 3'b100, 3'b000, 1'b1};
      vecs[6] = '{3'b010, 3'b010, 15'h0000, 1'b1, 12'h000, 3'b000, 3'b000, 3'b000, 1'b0};
      vecs[7] = '{3'b111, 3'b111, 15'h1234, 1'b0, 12'h111, 3'b000, 3'b000, 3'b000, 1'b0};
      for (int k = 0; k < 8; k++) begin
         valid = vecs[k].v; ready = vecs[k].r; data = vecs[k].d; clear = vecs[k].clr;
         step();
         check($sformatf("vec%0d", k), observe(),
               {vecs[k].cnt, vecs[k].drop, vecs[k].derr, vecs[k].serr, vecs[k].ae});
      end

      // ch0 saturation
      valid = '0; ready = '0; clear = 1'b1; step(); clear = 1'b0;
      valid = 3'b001; ready = 3'b001;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (k == 14) check("sat_14", observe(), {12'h00E, 10'b0});
         if (k == 15) check("sat_15", observe(), {12'h00F, 10'b0});
      end
      check("sat_20", observe(), {12'h00F, 10'b0});

      // ch0 stall boundary
      valid = '0; ready = '0; clear = 1'b1; step(); clear = 1'b0;
      valid = 3'b001; ready = 3'b000; data = 15'h0011;
      step(); step(); step();
      check("stall_3", observe(), '0);
      step();
      check("stall_4", observe(), {12'h000, 3'b000, 3'b000, 3'b001, 1'b1});
      ready = 3'b001;
      step();
      check("stall_xfer", observe(), {12'h001, 3'b000, 3'b000, 3'b001, 1'b1});

      // async reset mid-PEND
      valid = '0; ready = '0; clear = 1'b1; step(); clear = 1'b0;
      valid = 3'b001; ready = 3'b001; step();
      valid = 3'b100; ready = 3'b000; step();
      valid = 3'b000; step();
      valid = 3'b010; ready = 3'b000; step();
      check("pre_reset", observe(), {12'h001, 3'b100, 3'b000, 3'b000, 1'b1});
      #3 ASYNCRESET = 1'b1;
      #1 check("reset_async", observe(), '0);
      valid = 3'b000;
      step(); step();
      check("reset_hold", observe(), '0);
      ASYNCRESET = 1'b0;
      step();
      check("reset_release", observe(), '0);
      valid = 3'b010; ready = 3'b010; step();
      check("post_reset_xfer", observe(), {12'h010, 10'b0});

      // randomized run against the reference
      valid = '0; ready = '0; clear = 1'b1; step(); clear = 1'b0;
      model_clear();
      for (int k = 0; k < 3000; k++) begin
         for (int c = 0; c < N_CH; c++) begin
            rv[c] = ($urandom_range(0, 7) != 0);
            ready[c] = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 5) == 0) data[c*DATA_W +: DATA_W] = 5'($urandom);
         end
         valid = rv;
         clear = ($urandom_range(0, 39) == 0);
         model_edge();
         step();
         check($sformatf("rand%0d", k), observe(), model_obs());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/handshake_monitor.md
HANDSHAKE_MONITOR -- requirements
Module: handshake_monitor

Interface
REQ-001 SHALL have parameter N_CH, default 3: number of monitored ready/valid channels, range 1..16.
REQ-002 SHALL have parameter DATA_W, default 5: payload width per channel, at least 1.
REQ-003 SHALL have parameter CNT_W, default 16: transfer-counter width per channel.
REQ-004 SHALL have parameter STALL_MAX, default 15: number of consecutive stalled cycles that raises a stall error, at least 1.
REQ-005 SHALL have port CLK, input, 1 bit: single clock; all state updates on the rising edge.
REQ-006 SHALL have port ASYNCRESET, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port valid, input, N_CH bits: per-channel valid; bit i belongs to channel i.
REQ-008 SHALL have port ready, input, N_CH bits: per-channel ready.
REQ-009 SHALL have port data, input, N_CH*DATA_W bits: per-channel payload; channel i uses bits [i*DATA_W +: DATA_W].
REQ-010 SHALL have port clear, input, 1 bit: synchronous clear of all counters, error flags and channel state machines.
REQ-011 SHALL have port xfer_count, output, N_CH*CNT_W bits: per-channel count of completed transfers.
REQ-012 SHALL have port err_drop, output, N_CH bits: sticky flag, valid deasserted before its transfer completed.
REQ-013 SHALL have port err_data, output, N_CH bits: sticky flag, payload changed while a transfer was pending.
REQ-014 SHALL have port err_stall, output, N_CH bits: sticky flag, a transfer stayed pending for STALL_MAX cycles.
REQ-015 SHALL have port any_err, output, 1 bit: OR of all error flags.
REQ-016 SHALL be a passive observer: no output drives or feeds back into the monitored interface.

Function
REQ-017 SHALL run an independent two-state machine per channel, with states IDLE and PEND.
REQ-018 In IDLE, valid&ready SHALL increment the channel count; the channel stays in IDLE.
REQ-019 In IDLE, valid&!ready SHALL move the channel to PEND, capture data into a hold register and load the stall counter with 1.
REQ-020 In PEND, valid&ready SHALL increment the channel count, move the channel to IDLE and zero the stall counter.
REQ-021 In PEND, !valid SHALL set err_drop[i], move the channel to IDLE and zero the stall counter; the transfer is not counted.
REQ-022 In PEND, valid with data not equal to the hold register SHALL set err_data[i]; the hold register keeps the first captured value.
REQ-023 The err_data comparison SHALL apply even in a cycle where ready is high; the transfer in that cycle is still counted.
REQ-024 In PEND, valid&!ready SHALL increment the stall counter, saturating at STALL_MAX.
REQ-025 err_stall[i] SHALL be set on the edge at which the stall counter becomes STALL_MAX; STALL_MAX=1 sets it on the IDLE->PEND edge.
REQ-026 Transfer counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-027 Every error flag SHALL be registered and sticky: set on the edge that samples the violation, visible in the next cycle, held until clear or reset.
REQ-028 any_err SHALL be combinational from the registered flags, with no added latency.
REQ-029 clear=1 SHALL, on the next edge, zero all counters and flags and force every channel to IDLE.
REQ-030 clear SHALL take priority over a transfer or violation sampled in the same cycle; those events are discarded.
REQ-031 Channels SHALL be fully independent; simultaneous events on any number of channels SHALL all be recorded in the same cycle.

Reset
REQ-032 ASYNCRESET high SHALL immediately force all channels to IDLE, and all counters, stall counters, hold registers and flags to 0.
REQ-033 While ASYNCRESET is high, xfer_count, err_drop, err_data, err_stall and any_err SHALL all read 0.
REQ-034 A transfer pending when reset asserts SHALL be abandoned and SHALL NOT be counted or flagged after release.
REQ-035 The first edge after reset deasserts SHALL be a normal monitoring edge.

Configuration
REQ-036 With macro HANDSHAKE_MONITOR_ASSERT_EN defined, each rule violation SHALL additionally fire a concurrent assertion on CLK.
REQ-037 Those assertions SHALL be disabled while ASYNCRESET is high.
REQ-038 Each assertion failure SHALL report the channel index and the rule violated (drop, data or stall).
REQ-039 With HANDSHAKE_MONITOR_ASSERT_EN undefined, no assertions SHALL be elaborated; flag and counter behaviour SHALL be identical in both builds.

Verification (N_CH=3, DATA_W=5, CNT_W=4, STALL_MAX=4)
REQ-040 Ch0 has valid=ready=1 for 20 cycles -> xfer_count[0] reads 15 and saturates there; no flags set.
REQ-041 Ch1 has valid=1, ready=0 for 2 cycles, then valid=0 -> err_drop[1]=1 and any_err=1 from the following cycle; xfer_count[1]=0.
REQ-042 Ch2 has valid=1, ready=0, data 5'h0A then 5'h0B, then ready=1 -> err_data[2]=1 and xfer_count[2]=1.
REQ-043 Ch0 has valid=1, ready=0 for 4 cycles -> err_stall[0]=1 after the 4th edge; ready=1 on the 5th cycle gives xfer_count[0]=1 with err_stall still 1.
REQ-044 Ch1 transfers in the same cycle that clear=1 -> all outputs 0 next cycle; ASYNCRESET pulsed mid-PEND -> outputs 0 at once, no flag after release.
